bus_driver_reg: RTL and testbench
=================================

// Module: bus_driver_reg
// PURPOSE
//  Parametrised registered tristate bus driver with bus-turnaround sequencing.
//  It generalises the octal inverting buffer: the data width is configurable and polarity is selectable.
//  Input data is captured in a register; an enable sequencer applies a turn-on delay and a minimum
//  dead time after each release, so two drivers never fight on a shared bus.
//  It sits between a local data source and a shared tristate bus in the TTL model collection.
// PARAMETERS
//  WIDTH   8  data/bus width in bits (1..64)
//  INVERT  1  1: bus = ~data (inverting, '540 style); 0: bus = data
//  ON_DLY  1  extra clock edges between the sampled drive request and bus drive (0..15)
//  DEAD    1  minimum released edges after a drive ends before a new request is accepted (0..15)
// PORTS
//  clk   in   1      rising-edge clock
//  rst   in   1      synchronous reset, active-high
//  a     in   WIDTH  data input
//  le    in   1      load enable; when 1, a is captured into the data register at the edge
//  g1_   in   1      output enable, active-low
//  g2_   in   1      output enable, active-low; req = (g1_==0 && g2_==0)
//  q_    out  WIDTH  tristate bus output
//  oe    out  1      1 while q_ is driven
//  busy  out  1      1 in WAIT_ON or DEAD (turnaround in progress)
// BEHAVIOUR
//  - All state is registered at posedge clk. rst has priority over all other inputs.
//  - Reset values: data register d=0, state=IDLE, cnt=0, oe=0, busy=0, q_=all z.
//  - Data path: le=1 loads d<=a at the next edge; otherwise d holds.
//    q_ = oe ? (INVERT ? ~d : d) : {WIDTH{1'bz}} (combinational from registers).
//  - le is independent of the FSM; loading while driving updates q_ after the same edge.
//  - FSM states IDLE, WAIT_ON, DRIVE, DEAD. cnt width = $clog2(16).
//    IDLE:    req=1 & ON_DLY==0 -> DRIVE;
//             req=1 & ON_DLY>0  -> WAIT_ON, cnt<=ON_DLY-1; else stay.
//    WAIT_ON: req=0 -> IDLE (abort; no dead time, because the bus was never driven);
//             req=1 & cnt==0 -> DRIVE; else cnt<=cnt-1.
//    DRIVE:   req=0 & DEAD==0 -> IDLE; req=0 & DEAD>0 -> DEAD, cnt<=DEAD-1; else stay.
//    DEAD:    req is ignored; cnt==0 -> IDLE; else cnt<=cnt-1.
//  - oe=1 exactly in DRIVE. Drive latency = ON_DLY+1 edges of continuous req.
//    Release latency = 1 edge after req drops.
//  - Release is followed by exactly DEAD edges in DEAD, then IDLE. A request still held
//    at that point restarts the turn-on delay from IDLE.
//  - Reset mid-drive releases the bus at that edge and skips dead time.
//  - Glitch-free: oe never toggles on a req pulse shorter than ON_DLY+1 edges.
// CONFIGURATION
//  Macro PARITY_EN.
//  Defined: adds output port par (1 bit) = ^(driven q_ value) when oe=1, z otherwise.
//    Even parity over the bus lines as driven, so it follows INVERT.
//  Undefined: the port par and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  Package bus_driver_pkg:
//    - state enum typedef (IDLE=0, WAIT_ON=1, DRIVE=2, DEAD=3)
//    - CNT_W=4
//    - delay-range limit constants
//  Sub-module turnaround_fsm (clk, rst, req, oe, busy; parameters ON_DLY, DEAD) holds the FSM
//  and counter. The top level holds the data register, polarity mux and tristate/parity logic.
// TESTING
//  1. WIDTH=8, INVERT=1, ON_DLY=1: rst, le=1 a=8'h5A, then g1_=g2_=0.
//     -> q_=z for 1 edge, then q_=8'hA5, oe=1.
//  2. INVERT=0, ON_DLY=0, DEAD=2: drive, then g2_=1.
//     -> q_=z after 1 edge; busy=1 for 2 edges; req re-asserted in DEAD is ignored
//        until IDLE, then drives 1 edge later.
//  3. ON_DLY=3: req pulse of 2 edges.
//     -> oe stays 0, busy 1 then 0, returns to IDLE with no dead time.
//  4. While driving 8'h0F (INVERT=0): le=1 a=8'hF0.
//     -> q_=8'hF0 after that edge, oe stays 1.
//  5. rst=1 asserted in DRIVE and in DEAD.
//     -> next edge: q_=z, oe=0, busy=0, d=0; req after rst release obeys full ON_DLY.
//  6. PARITY_EN, INVERT=1, d=8'h01.
//     -> q_=8'hFE, par=1; after release par=z.

Source files
------------

// File: rtl/bus_driver_pkg.sv
// Shared types and limits for the registered tristate bus driver.
// State encoding is fixed so waveforms read the same across builds.
package bus_driver_pkg;

    localparam int CNT_W     = 4;
    localparam int DLY_MAX   = 15;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_ON = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_DEAD    = 2'd3
    } state_e;

endpackage

// File: rtl/bus_driver_reg_fsm.sv
// Turn-on delay and dead-time sequencer for one bus driver.
// oe is high only in ST_DRIVE; busy covers both turnaround phases.
module turnaround_fsm
    import bus_driver_pkg::*;
#(
    parameter int ON_DLY = 1,
    parameter int DEAD   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic oe,
    output logic busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (ON_DLY == 0) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_WAIT_ON;
                        cnt_d   = CNT_W'(ON_DLY - 1);
                    end
                end
            end
            ST_WAIT_ON: begin
                // dropping req here skips dead time: the bus was never driven
                if (!req)
                    state_d = ST_IDLE;
                else if (cnt_q == '0)
                    state_d = ST_DRIVE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            ST_DRIVE: begin
                if (!req) begin
                    if (DEAD == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DEAD;
                        cnt_d   = CNT_W'(DEAD - 1);
                    end
                end
            end
            ST_DEAD: begin
                if (cnt_q == '0)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign oe   = (state_q == ST_DRIVE);
    assign busy = (state_q == ST_WAIT_ON) || (state_q == ST_DEAD);

endmodule

// File: rtl/bus_driver_reg.sv
// Registered tristate bus driver with selectable polarity and turnaround.
// Optional feature macro PARITY_EN adds an even-parity output par.
module bus_driver_reg
    import bus_driver_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int INVERT = 1,
    parameter int ON_DLY = 1,
    parameter int DEAD   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             le,
    input  logic             g1_,
    input  logic             g2_,
    output logic [WIDTH-1:0] q_,
`ifdef PARITY_EN
    output logic             par,
`endif
    output logic             oe,
    output logic             busy
);

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] drv;
    logic             req;

    assign req = !g1_ && !g2_;

    always_comb begin
        d_d = d_q;
        if (le)
            d_d = a;
    end

    always_ff @(posedge clk) begin
        if (rst)
            d_q <= '0;
        else
            d_q <= d_d;
    end

    turnaround_fsm #(
        .ON_DLY (ON_DLY),
        .DEAD   (DEAD)
    ) u_fsm (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .oe   (oe),
        .busy (busy)
    );

    assign drv = (INVERT != 0) ? ~d_q : d_q;
    assign q_  = oe ? drv : {WIDTH{1'bz}};

`ifdef PARITY_EN
    assign par = oe ? ^drv : 1'bz;
`endif

endmodule

// File: tb/tb_bus_driver_reg.sv
// Random scoreboard bench for bus_driver_reg with two parameter sets.
// Define PARITY_EN at compile time to also check par.
module tb_bus_driver_reg;

    localparam int W      = 8;
    localparam int NCYC   = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic         le, g1_, g2_;
    logic [W-1:0] q0, q1;
    logic         oe0, oe1, busy0, busy1;
`ifdef PARITY_EN
    logic         par0, par1;
`endif

    always #5 clk = ~clk;

    bus_driver_reg #(.WIDTH(W), .INVERT(1), .ON_DLY(2), .DEAD(2)) u0 (
        .clk(clk), .rst(rst), .a(a), .le(le), .g1_(g1_), .g2_(g2_),
        .q_(q0),
`ifdef PARITY_EN
        .par(par0),
`endif
        .oe(oe0), .busy(busy0)
    );

    bus_driver_reg #(.WIDTH(W), .INVERT(0), .ON_DLY(0), .DEAD(0)) u1 (
        .clk(clk), .rst(rst), .a(a), .le(le), .g1_(g1_), .g2_(g2_),
        .q_(q1),
`ifdef PARITY_EN
        .par(par1),
`endif
        .oe(oe1), .busy(busy1)
    );

    typedef struct {
        logic         oe  [2];
        logic         busy[2];
        logic [W-1:0] q   [2];
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: delays expressed as run lengths and countdowns
    int           on_cfg  [2] = '{2, 0};
    int           dead_cfg[2] = '{2, 0};
    bit           inv_cfg [2] = '{1'b1, 1'b0};
    int           run     [2];
    int           dead_left[2];
    bit           driving [2];
    logic [W-1:0] m_d;

    task automatic model_edge(input bit r, input bit rq, input bit l,
                              input logic [W-1:0] av);
        exp_t e;
        if (r) m_d = '0;
        else if (l) m_d = av;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                driving[k]   = 0;
                run[k]       = 0;
                dead_left[k] = 0;
            end else if (dead_left[k] > 0) begin
                dead_left[k]--;
                run[k] = 0;
            end else if (driving[k]) begin
                if (!rq) begin
                    driving[k]   = 0;
                    dead_left[k] = dead_cfg[k];
                    run[k]       = 0;
                end
            end else if (rq) begin
                run[k]++;
                if (run[k] == on_cfg[k] + 1) begin
                    driving[k] = 1;
                    run[k]     = 0;
                end
            end else begin
                run[k] = 0;
            end
            e.oe[k]   = driving[k];
            e.busy[k] = (dead_left[k] > 0) || (run[k] > 0);
            e.q[k]    = inv_cfg[k] ? ~m_d : m_d;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req_v, $time);
        end
    endtask

    // monitor: one expected entry per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("oe0",   W'(oe0),   W'(e.oe[0]));
                chk("busy0", W'(busy0), W'(e.busy[0]));
                chk("oe1",   W'(oe1),   W'(e.oe[1]));
                chk("busy1", W'(busy1), W'(e.busy[1]));
                if (e.oe[0]) begin
                    chk("q0", q0, e.q[0]);
`ifdef PARITY_EN
                    chk("par0", W'(par0), W'(^e.q[0]));
`endif
                end
                if (e.oe[1]) begin
                    chk("q1", q1, e.q[1]);
`ifdef PARITY_EN
                    chk("par1", W'(par1), W'(^e.q[1]));
`endif
                end
            end
        end
    end

    initial begin
        bit rq;
        rq = 0;
        m_d = '0;
        for (int k = 0; k < 2; k++) begin
            run[k] = 0;
            dead_left[k] = 0;
            driving[k] = 0;
        end
        for (int i = 0; i < NCYC; i++) begin
            if (i > 0) @(negedge clk);
            rst = (i < 2) || ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) rq = ~rq;
            le  = ($urandom_range(0, 2) == 0);
            a   = W'($urandom);
            g1_ = ~rq;
            g2_ = rq ? 1'b0 : 1'($urandom);
            model_edge(rst, rq, le, a);
        end
        @(negedge clk);
        rst = 1'b0;
        g1_ = 1'b1;
        g2_ = 1'b1;
        le  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
